addr_mem_reader: RTL and testbench

- Stage directly downstream of the address generator. Consumes its address stream (valid/ready/addr) and issues reads to a synchronous single-port memory with fixed read latency.
- Buffers returned words in a small FIFO and presents them as a valid/ready data stream to the unit datapath.
- Back-pressures the generator by credit, so no returned word is ever dropped. Signals completion only once all issued reads have drained.

---
 rtl/versat_stream_pkg.sv | 20 ++
 rtl/versat_sync_fifo.sv | 74 +++++++
 rtl/addr_mem_reader.sv | 87 ++++++++
 tb/tb_addr_mem_reader.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/versat_stream_pkg.sv
// Shared helpers for the versat streaming stages: ceil-log2 and the
// legality check for memory latency versus FIFO depth.
package versat_stream_pkg;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((32'sd1 << r) < v) begin
            r = r + 1;
        end
        return r;
    endfunction

    // A word may already be in flight for every entry, so depth must cover LAT+1.
    function automatic bit cfg_ok(input int lat, input int depth);
        return (lat >= 1) && (lat <= 4) && (depth >= lat + 1) &&
               ((depth & (depth - 1)) == 0);
    endfunction

endpackage

// File: rtl/versat_sync_fifo.sv
// Small synchronous FIFO with registered storage and combinational head read.
// No overflow protection: the caller guarantees a push never meets a full FIFO.
module versat_sync_fifo
    import versat_stream_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     clr_i,
    input  logic                     push_i,
    input  logic [DATA_W-1:0]        wdata_i,
    input  logic                     pop_i,
    output logic [clog2(DEPTH):0]    occ_o,
    output logic [DATA_W-1:0]        head_o
);
    localparam int PTR_W = clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]    occ_q, occ_d;

    // Next pointer/occupancy; pointers wrap naturally since DEPTH is a power of 2.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            occ_d    = '0;
        end else begin
            if (push_i) begin
                wr_ptr_d = wr_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = rd_ptr_q + {{(PTR_W-1){1'b0}}, 1'b1};
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   occ_d = occ_q + {{PTR_W{1'b0}}, 1'b1};
                2'b01:   occ_d = occ_q - {{PTR_W{1'b0}}, 1'b1};
                default: occ_d = occ_q;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i && !clr_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    assign occ_o  = occ_q;
    assign head_o = mem_q[rd_ptr_q];

endmodule

// File: rtl/addr_mem_reader.sv
// Turns the generator's address stream into memory reads and re-streams the
// returned words, throttling acceptance by credit so no returned word is lost.
module addr_mem_reader
    import versat_stream_pkg::*;
#(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32,
    parameter int LAT    = 1,
    parameter int DEPTH  = 4
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              run_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic              done_i,
    output logic              mem_en_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    output logic              data_valid_o,
    input  logic              data_ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              done_o
);
    localparam int OCC_W = clog2(DEPTH) + 1;

    if (!cfg_ok(LAT, DEPTH)) begin : g_cfg_err
        $error("addr_mem_reader: DEPTH must be a power of 2 and >= LAT+1, LAT in 1..4");
    end

    logic [LAT-1:0]   inflight_q, inflight_d;
    logic [OCC_W-1:0] occ_s;
    logic [OCC_W:0]   pending_s;
    logic             acc_s, push_s, pop_s;

    // Credit: words buffered plus words still travelling back from memory.
    always_comb begin
        pending_s = {1'b0, occ_s};
        for (int i = 0; i < LAT; i++) begin
            pending_s = pending_s + {{OCC_W{1'b0}}, inflight_q[i]};
        end
    end

    assign ready_o    = !rst_i && !run_i && (pending_s < (OCC_W+1)'(DEPTH));
    assign acc_s      = valid_i && ready_o;
    assign mem_en_o   = acc_s;
    assign mem_addr_o = addr_i;

    if (LAT == 1) begin : g_lat1
        assign inflight_d = acc_s;
    end else begin : g_latn
        assign inflight_d = {inflight_q[LAT-2:0], acc_s};
    end

    // A flush discards whatever the memory is still returning.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inflight_q <= '0;
        end else if (run_i) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

    assign push_s       = inflight_q[LAT-1] && !run_i;
    assign data_valid_o = (occ_s != '0);
    assign pop_s        = data_valid_o && data_ready_i && !run_i;

    versat_sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .clr_i   (run_i),
        .push_i  (push_s),
        .wdata_i (mem_rdata_i),
        .pop_i   (pop_s),
        .occ_o   (occ_s),
        .head_o  (data_o)
    );

    assign done_o = !rst_i && done_i && !run_i && (occ_s == '0) && (inflight_q == '0);

endmodule

// File: tb/tb_addr_mem_reader.sv
// Directed bench: three reader instances (LAT/DEPTH = 1/4, 3/8, 3/4) share one
// stimulus; each has a memory model returning mem[a] = a + 100.
module tb_addr_mem_reader;
    logic        clk = 1'b0;
    logic        rst, run, valid, done_in, data_ready;
    logic [9:0]  addr;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        rdy_a, men_a, dv_a, dn_a;
    logic        rdy_b, men_b, dv_b, dn_b;
    logic        rdy_c, men_c, dv_c, dn_c;
    logic [9:0]  madr_a, madr_b, madr_c;
    logic [31:0] rdat_a, rdat_b, rdat_c, do_a, do_b, do_c;
    logic [31:0] pa, pb0, pb1, pb2, pc0, pc1, pc2;

    int qa_d[$], qa_c[$], qb_d[$], qb_c[$], qc_d[$];
    int nxt, t0, stalls;

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        pa  <= 32'(madr_a) + 32'd100;
        pb0 <= 32'(madr_b) + 32'd100; pb1 <= pb0; pb2 <= pb1;
        pc0 <= 32'(madr_c) + 32'd100; pc1 <= pc0; pc2 <= pc1;
    end
    assign rdat_a = pa;
    assign rdat_b = pb2;
    assign rdat_c = pc2;

    addr_mem_reader #(.ADDR_W(10), .DATA_W(32), .LAT(1), .DEPTH(4)) dut_a (
        .clk_i(clk), .rst_i(rst), .run_i(run), .valid_i(valid), .ready_o(rdy_a),
        .addr_i(addr), .done_i(done_in), .mem_en_o(men_a), .mem_addr_o(madr_a),
        .mem_rdata_i(rdat_a), .data_valid_o(dv_a), .data_ready_i(data_ready),
        .data_o(do_a), .done_o(dn_a));
    addr_mem_reader #(.ADDR_W(10), .DATA_W(32), .LAT(3), .DEPTH(8)) dut_b (
        .clk_i(clk), .rst_i(rst), .run_i(run), .valid_i(valid), .ready_o(rdy_b),
        .addr_i(addr), .done_i(done_in), .mem_en_o(men_b), .mem_addr_o(madr_b),
        .mem_rdata_i(rdat_b), .data_valid_o(dv_b), .data_ready_i(data_ready),
        .data_o(do_b), .done_o(dn_b));
    addr_mem_reader #(.ADDR_W(10), .DATA_W(32), .LAT(3), .DEPTH(4)) dut_c (
        .clk_i(clk), .rst_i(rst), .run_i(run), .valid_i(valid), .ready_o(rdy_c),
        .addr_i(addr), .done_i(done_in), .mem_en_o(men_c), .mem_addr_o(madr_c),
        .mem_rdata_i(rdat_c), .data_valid_o(dv_c), .data_ready_i(data_ready),
        .data_o(do_c), .done_o(dn_c));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Record every word handed to the consumer, with the cycle it left.
    always @(negedge clk) begin
        if (!rst && data_ready) begin
            if (dv_a) begin qa_d.push_back(int'(do_a)); qa_c.push_back(cyc); end
            if (dv_b) begin qb_d.push_back(int'(do_b)); qb_c.push_back(cyc); end
            if (dv_c) qc_d.push_back(int'(do_c));
        end
    end

    // Credit must never let a returning word meet a full FIFO.
    always @(posedge clk) begin
        if (!rst && dut_a.push_s) begin
            n_cmp++;
            assert (dut_a.occ_s < 3'd4) else begin
                n_err++;
                $error("FAIL push_full_a: observed occ %0d expected below 4", dut_a.occ_s);
            end
        end
        if (!rst && dut_c.push_s) begin
            n_cmp++;
            assert (dut_c.occ_s < 3'd4) else begin
                n_err++;
                $error("FAIL push_full_c: observed occ %0d expected below 4", dut_c.occ_s);
            end
        end
    end

    initial begin
        rst = 1'b1; run = 1'b0; valid = 1'b1; addr = 10'd0; done_in = 1'b1; data_ready = 1'b0;
        // Reset state
        @(negedge clk);
        chk("rst_ready", 32'(rdy_a), 32'd0);
        chk("rst_mem_en", 32'(men_a), 32'd0);
        chk("rst_dvalid", 32'(dv_a), 32'd0);
        chk("rst_done", 32'(dn_a), 32'd0);
        tick();
        rst = 1'b0; valid = 1'b0; done_in = 1'b0; data_ready = 1'b1;
        tick();

        // Streaming 0..7 back to back
        qa_d.delete(); qa_c.delete();
        t0 = 0;
        for (int i = 0; i < 8; i++) begin
            valid = 1'b1; addr = 10'(i);
            @(negedge clk);
            chk($sformatf("stream_ready_%0d", i), 32'(rdy_a), 32'd1);
            if (i == 0) t0 = cyc;
            tick();
        end
        valid = 1'b0;
        repeat (5) tick();
        chk("stream_count", 32'(qa_d.size()), 32'd8);
        for (int k = 0; k < qa_d.size() && k < 8; k++) begin
            chk($sformatf("stream_data_%0d", k), 32'(qa_d[k]), 32'(100 + k));
            chk($sformatf("stream_cyc_%0d", k), 32'(qa_c[k]), 32'(t0 + 2 + k));
        end

        // Back-pressure: consumer stalled, generator holds until accepted
        qa_d.delete(); qa_c.delete();
        data_ready = 1'b0; nxt = 0;
        for (int k = 0; k < 10; k++) begin
            valid = 1'b1; addr = 10'(nxt);
            @(negedge clk);
            if (rdy_a) nxt++;
            tick();
        end
        @(negedge clk);
        chk("bp_accepted", 32'(nxt), 32'd4);
        chk("bp_ready", 32'(rdy_a), 32'd0);
        chk("bp_occ", 32'(dut_a.occ_s), 32'd4);
        data_ready = 1'b1;
        for (int k = 0; k < 40 && nxt < 10; k++) begin
            valid = 1'b1; addr = 10'(nxt);
            @(negedge clk);
            if (rdy_a) nxt++;
            tick();
        end
        valid = 1'b0;
        repeat (8) tick();
        chk("bp_all_accepted", 32'(nxt), 32'd10);
        chk("bp_count", 32'(qa_d.size()), 32'd10);
        for (int k = 0; k < qa_d.size() && k < 10; k++)
            chk($sformatf("bp_data_%0d", k), 32'(qa_d[k]), 32'(100 + k));

        // Done only after both in-flight words are popped
        qa_d.delete(); qa_c.delete();
        data_ready = 1'b0;
        valid = 1'b1; addr = 10'd40;
        @(negedge clk); chk("done_acc0", 32'(rdy_a), 32'd1); tick();
        addr = 10'd41;
        @(negedge clk); chk("done_acc1", 32'(rdy_a), 32'd1); tick();
        valid = 1'b0; done_in = 1'b1;
        @(negedge clk); chk("done_inflight", 32'(dn_a), 32'd0); tick();
        @(negedge clk); chk("done_occ2", 32'(dn_a), 32'd0);
        chk("done_occ2_occ", 32'(dut_a.occ_s), 32'd2); tick();
        data_ready = 1'b1;
        @(negedge clk); chk("done_pop0", 32'(dn_a), 32'd0); tick();
        @(negedge clk); chk("done_pop1", 32'(dn_a), 32'd0); tick();
        @(negedge clk); chk("done_empty", 32'(dn_a), 32'd1); tick();
        done_in = 1'b0;
        @(negedge clk); chk("done_fall", 32'(dn_a), 32'd0);
        chk("done_words", 32'(qa_d.size()), 32'd2);
        if (qa_d.size() == 2) begin
            chk("done_w0", 32'(qa_d[0]), 32'd140);
            chk("done_w1", 32'(qa_d[1]), 32'd141);
        end
        tick();

        // Flush with occ=3 and one word in flight
        data_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            valid = 1'b1; addr = 10'(20 + i);
            @(negedge clk); chk($sformatf("flush_acc_%0d", i), 32'(rdy_a), 32'd1);
            tick();
        end
        addr = 10'd50; run = 1'b1;
        @(negedge clk);
        chk("flush_ready", 32'(rdy_a), 32'd0);
        chk("flush_mem_en", 32'(men_a), 32'd0);
        chk("flush_pre_occ", 32'(dut_a.occ_s), 32'd3);
        chk("flush_pre_inflight", 32'(dut_a.inflight_q), 32'd1);
        tick();
        run = 1'b0; valid = 1'b0;
        @(negedge clk);
        chk("flush_dvalid", 32'(dv_a), 32'd0);
        chk("flush_occ", 32'(dut_a.occ_s), 32'd0);
        tick();
        @(negedge clk);
        chk("flush_no_late", 32'(dv_a), 32'd0);
        tick();
        qa_d.delete(); qa_c.delete();
        data_ready = 1'b1; valid = 1'b1; addr = 10'd9;
        @(negedge clk); chk("flush_new_acc", 32'(men_a), 32'd1); tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("flush_new_count", 32'(qa_d.size()), 32'd1);
        if (qa_d.size() == 1) chk("flush_new_data", 32'(qa_d[0]), 32'd109);

        // Latency sweep on LAT=3 instances
        qb_d.delete(); qb_c.delete(); qc_d.delete();
        valid = 1'b1; addr = 10'd5;
        @(negedge clk);
        chk("lat_en_b", 32'(men_b), 32'd1);
        chk("lat_en_c", 32'(men_c), 32'd1);
        t0 = cyc;
        tick();
        valid = 1'b0;
        repeat (8) tick();
        chk("lat_count_b", 32'(qb_d.size()), 32'd1);
        if (qb_d.size() == 1) begin
            chk("lat_data_b", 32'(qb_d[0]), 32'd105);
            chk("lat_cyc_b", 32'(qb_c[0]), 32'(t0 + 4));
        end
        chk("lat_count_c", 32'(qc_d.size()), 32'd1);
        if (qc_d.size() == 1) chk("lat_data_c", 32'(qc_d[0]), 32'd105);

        // DEPTH=LAT+1: correct order at reduced rate
        qc_d.delete(); nxt = 0; stalls = 0;
        for (int k = 0; k < 60 && nxt < 8; k++) begin
            valid = 1'b1; addr = 10'(nxt);
            @(negedge clk);
            if (rdy_c) nxt++; else stalls++;
            tick();
        end
        valid = 1'b0;
        repeat (8) tick();
        chk("slow_accepted", 32'(nxt), 32'd8);
        chk("slow_stalled", 32'(stalls != 0), 32'd1);
        chk("slow_count", 32'(qc_d.size()), 32'd8);
        for (int k = 0; k < qc_d.size() && k < 8; k++)
            chk($sformatf("slow_data_%0d", k), 32'(qc_d[k]), 32'(100 + k));

        // Asynchronous reset between edges
        data_ready = 1'b0; valid = 1'b1; addr = 10'd60;
        tick(); tick();
        chk("arst_pre_dvalid", 32'(dv_a), 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("arst_dvalid", 32'(dv_a), 32'd0);
        chk("arst_ready", 32'(rdy_a), 32'd0);
        chk("arst_mem_en", 32'(men_a), 32'd0);
        tick();
        rst = 1'b0; valid = 1'b0; data_ready = 1'b1;
        qa_d.delete(); qa_c.delete();
        tick();
        valid = 1'b1; addr = 10'd33;
        @(negedge clk); chk("arst_new_acc", 32'(rdy_a), 32'd1); tick();
        valid = 1'b0;
        repeat (5) tick();
        chk("arst_new_count", 32'(qa_d.size()), 32'd1);
        if (qa_d.size() == 1) chk("arst_new_data", 32'(qa_d[0]), 32'd133);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
